// File: rtl/redmule_w_buffer_ctrl.sv
// redmule_w_buffer_ctrl: sequencer for the W-buffer latch-based SCM.
// It fills the buffer row by row from the W streamer, waits one cycle for the
// latches to settle, and then walks the read schedule for the systolic array:
// the element index is the inner loop and the column-pass offset is the outer loop.
// This repeats for n_tiles W tiles and ends with a one-cycle done pulse.
// ROWS must equal COLS because the SCM's skewed column addressing relies on it.
// Optional feature macro: REDMULE_WBUF_CTRL_PERF_EN adds two saturating
// performance counters (stream stalls and fill waits).
module redmule_w_buffer_ctrl #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned ELMS       = 4,
  parameter int unsigned TILE_CNT_W = 16,
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned EW = (ELMS > 1) ? $clog2(ELMS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [TILE_CNT_W-1:0] n_tiles_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  output logic                  buf_write_en_o,
  output logic [RW-1:0]         buf_write_addr_o,
  input  logic                  feed_ready_i,
  output logic                  buf_read_en_o,
  output logic [EW-1:0]         buf_elms_read_addr_o,
  output logic [CW-1:0]         buf_cols_read_offs_o,
  output logic [ROWS*RW-1:0]    buf_rows_read_addr_o,
  output logic                  rdata_valid_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef REDMULE_WBUF_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt_o,
  output logic [31:0]           perf_fill_wait_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SETTLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [RW-1:0]         row_cnt;
  logic [EW-1:0]         elm_cnt;
  logic [CW-1:0]         pass_cnt;
  logic [TILE_CNT_W-1:0] tile_cnt;
  logic [TILE_CNT_W-1:0] tile_next;
  logic [TILE_CNT_W-1:0] n_tiles_q;
  logic                  rdata_valid_q;
  logic                  write_hs;
  logic                  read_beat;
  logic                  last_row;
  logic                  last_elm;
  logic                  last_pass;

  // A row is written on every FILL handshake; a read beat is issued whenever
  // the array can take one during STREAM. The two states are disjoint, so the
  // write and read enables can never be high together.
  assign write_hs  = (state_q == S_FILL) && w_valid_i;
  assign read_beat = (state_q == S_STREAM) && feed_ready_i;
  assign last_row  = (row_cnt == RW'(ROWS - 1));
  assign last_elm  = (elm_cnt == EW'(ELMS - 1));
  assign last_pass = (pass_cnt == CW'(COLS - 1));
  assign tile_next = tile_cnt + TILE_CNT_W'(1);

  assign w_ready_o            = (state_q == S_FILL);
  assign buf_write_en_o       = write_hs;
  assign buf_write_addr_o     = row_cnt;
  assign buf_read_en_o        = read_beat;
  assign buf_elms_read_addr_o = elm_cnt;
  assign buf_cols_read_offs_o = pass_cnt;
  assign rdata_valid_o        = rdata_valid_q;
  assign busy_o               = (state_q != S_IDLE);
  assign done_o               = (state_q == S_DONE);

  // Row r of the array always reads buffer row r; the skew lives in the SCM.
  for (genvar r = 0; r < ROWS; r++) begin : g_rows
    assign buf_rows_read_addr_o[r*RW +: RW] = RW'(r);
  end

  // Job sequencer: abort behaves like reset and wins over every transition.
  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      state_q       <= S_IDLE;
      row_cnt       <= '0;
      elm_cnt       <= '0;
      pass_cnt      <= '0;
      tile_cnt      <= '0;
      n_tiles_q     <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      rdata_valid_q <= read_beat;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            row_cnt  <= '0;
            elm_cnt  <= '0;
            pass_cnt <= '0;
            tile_cnt <= '0;
            if (n_tiles_i == '0) begin
              state_q <= S_DONE;
            end else begin
              n_tiles_q <= n_tiles_i;
              state_q   <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (write_hs) begin
            if (last_row) begin
              row_cnt <= '0;
              state_q <= S_SETTLE;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        S_SETTLE: state_q <= S_STREAM;
        S_STREAM: begin
          if (read_beat) begin
            if (last_elm) begin
              elm_cnt <= '0;
              if (last_pass) begin
                pass_cnt <= '0;
                tile_cnt <= tile_next;
                if (tile_next == n_tiles_q) begin
                  state_q <= S_DRAIN;
                end else begin
                  row_cnt <= '0;
                  state_q <= S_FILL;
                end
              end else begin
                pass_cnt <= pass_cnt + CW'(1);
              end
            end else begin
              elm_cnt <= elm_cnt + EW'(1);
            end
          end
        end
        S_DRAIN: state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef REDMULE_WBUF_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fill_wait_cnt_q;

  // Saturating stall / fill-wait counters, restarted when a job is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q     <= '0;
      fill_wait_cnt_q <= '0;
    end else if ((state_q == S_IDLE) && start_i && !abort_i) begin
      stall_cnt_q     <= '0;
      fill_wait_cnt_q <= '0;
    end else begin
      if ((state_q == S_STREAM) && !feed_ready_i && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if ((state_q == S_FILL) && !w_valid_i && (fill_wait_cnt_q != '1)) begin
        fill_wait_cnt_q <= fill_wait_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt_o     = stall_cnt_q;
  assign perf_fill_wait_cnt_o = fill_wait_cnt_q;
`endif

endmodule
